regbank8: RTL

- Eight-entry, N-bit register bank whose eight registered outputs drive the eight data inputs of the 8:1 selector stage directly downstream.
- Provides one synchronous write port with byte strobes, a bulk clear, a global enable and a per-entry "written" status mask.
- Used as a small operand/scratch store in the datapath; the downstream selector picks one entry by its 3-bit select.

---
 rtl/regbank8_if.sv | 24 ++
 rtl/regbank8.sv | 64 ++++++
 2 files changed

// File: rtl/regbank8_if.sv
// Bus interface for regbank8: write port, control, and the eight entry outputs plus status.
interface regbank8_if #(
  parameter int unsigned N = 32
);
  logic           ena;
  logic           we;
  logic [2:0]     waddr;
  logic [N-1:0]   wdata;
  logic [N/8-1:0] wstrb;
  logic           clear;
  logic [N-1:0]   q0, q1, q2, q3, q4, q5, q6, q7;
  logic [7:0]     written_mask;
  logic           wr_err;

  modport master (
    output ena, we, waddr, wdata, wstrb, clear,
    input  q0, q1, q2, q3, q4, q5, q6, q7, written_mask, wr_err
  );

  modport slave (
    input  ena, we, waddr, wdata, wstrb, clear,
    output q0, q1, q2, q3, q4, q5, q6, q7, written_mask, wr_err
  );
endinterface

// File: rtl/regbank8.sv
// Eight-entry N-bit register bank with byte-strobed write, bulk clear, enable and written mask.
// Optional REGBANK8_ZERO_ENTRY_EN: entry 0 hardwired to zero and unwritable.
module regbank8 #(
  parameter int unsigned   N         = 32,
  parameter logic [N-1:0]  RESET_VAL = '0
) (
  input logic         clk,
  input logic         rst,
  regbank8_if.slave   bus
);
  localparam int unsigned NB = N / 8;

  logic [N-1:0] entry [8];
  logic [7:0]   mask;
  logic         err;
  logic         wr_ok;

`ifdef REGBANK8_ZERO_ENTRY_EN
  assign wr_ok = (bus.waddr != 3'd0);
`else
  assign wr_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 8; i++) entry[i] <= RESET_VAL;
      mask <= '0;
      err  <= 1'b0;
    end else begin
      err <= 1'b0;
      if (bus.ena) begin
        if (bus.clear) begin
          for (int unsigned i = 0; i < 8; i++) entry[i] <= RESET_VAL;
          mask <= '0;
        end else if (bus.we && wr_ok) begin
          // Zero-strobe write leaves all state untouched and only flags the error.
          if (bus.wstrb == '0) begin
            err <= 1'b1;
          end else begin
            mask[bus.waddr] <= 1'b1;
            for (int unsigned k = 0; k < NB; k++) begin
              if (bus.wstrb[k]) entry[bus.waddr][8*k +: 8] <= bus.wdata[8*k +: 8];
            end
          end
        end
      end
    end
  end

`ifdef REGBANK8_ZERO_ENTRY_EN
  assign bus.q0 = '0;
`else
  assign bus.q0 = entry[0];
`endif
  assign bus.q1           = entry[1];
  assign bus.q2           = entry[2];
  assign bus.q3           = entry[3];
  assign bus.q4           = entry[4];
  assign bus.q5           = entry[5];
  assign bus.q6           = entry[6];
  assign bus.q7           = entry[7];
  assign bus.written_mask = mask;
  assign bus.wr_err       = err;
endmodule
